// File: rtl/gates_mux_sweep_checker.sv
// Stimulus/response sequencer for the MUX2X1 gate self-check: sweeps {a,b} over all
// four vectors N_PASSES times, tallies fail_i and reports a registered verdict.
// Optional: define GATES_SWEEP_ABORT_ON_FAIL_EN to end the run on the first failing sample.
module gates_mux_sweep_checker #(
   parameter int N_PASSES      = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8,
   localparam int PASS_W       = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              fail_i,
   output logic              a_o,
   output logic              b_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [CNT_W-1:0]  fail_cnt_o,
   output logic              first_fail_vld_o,
   output logic [1:0]        first_fail_vec_o,
   output logic [PASS_W-1:0] first_fail_pass_o
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(N_PASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          vec_q, vec_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
   logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
   logic                ff_vld_q, ff_vld_d;
   logic [1:0]          ff_vec_q, ff_vec_d;
   logic [PASS_W-1:0]   ff_pass_q, ff_pass_d;
   logic                pass_q, pass_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         settle_q   <= '0;
         pass_idx_q <= '0;
         fail_cnt_q <= '0;
         ff_vld_q   <= 1'b0;
         ff_vec_q   <= '0;
         ff_pass_q  <= '0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         settle_q   <= settle_d;
         pass_idx_q <= pass_idx_d;
         fail_cnt_q <= fail_cnt_d;
         ff_vld_q   <= ff_vld_d;
         ff_vec_q   <= ff_vec_d;
         ff_pass_q  <= ff_pass_d;
         pass_q     <= pass_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      settle_d   = settle_q;
      pass_idx_d = pass_idx_q;
      fail_cnt_d = fail_cnt_q;
      ff_vld_d   = ff_vld_q;
      ff_vec_d   = ff_vec_q;
      ff_pass_d  = ff_pass_q;
      pass_d     = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_DRIVE;
               vec_d      = '0;
               settle_d   = '0;
               pass_idx_d = '0;
               fail_cnt_d = '0;
               ff_vld_d   = 1'b0;
               ff_vec_d   = '0;
               ff_pass_d  = '0;
               pass_d     = 1'b0;
            end
         end
         S_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = S_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            if (fail_i) begin
               if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
               if (!ff_vld_q) begin
                  ff_vld_d  = 1'b1;
                  ff_vec_d  = vec_q;
                  ff_pass_d = pass_idx_q;
               end
            end
            if (vec_q != 2'd3) begin
               vec_d   = vec_q + 2'd1;
               state_d = S_DRIVE;
            end else if (pass_idx_q != PASS_LAST) begin
               vec_d      = '0;
               pass_idx_d = pass_idx_q + 1'b1;
               state_d    = S_DRIVE;
            end else begin
               state_d = S_DONE;
            end
`ifdef GATES_SWEEP_ABORT_ON_FAIL_EN
            if (fail_i) state_d = S_DONE;
`endif
            // Verdict uses the count including this final sample; saturation never wraps to zero.
            if (state_d == S_DONE) pass_d = (fail_cnt_d == '0);
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_o            = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign done_o            = (state_q == S_DONE);
   assign a_o               = busy_o & vec_q[1];
   assign b_o               = busy_o & vec_q[0];
   assign pass_o            = pass_q;
   assign fail_cnt_o        = fail_cnt_q;
   assign first_fail_vld_o  = ff_vld_q;
   assign first_fail_vec_o  = ff_vec_q;
   assign first_fail_pass_o = ff_pass_q;

endmodule
